// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: single-character ASCII command endpoint feeding a UART tx handshake.
// Optional build macro UART_ECHO_EN prepends the received command byte to every reply.
module uart_cmd_responder #(
    parameter int ACK_TO_W = 16,
    parameter int MAX_LEN  = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_done,
    input  logic       i_tx_busy,
    output logic [7:0] o_tx_data,
    output logic       o_tx_start,
    input  logic [4:0] i_hour,
    input  logic [5:0] i_min,
    input  logic [5:0] i_sec,
    output logic       o_cmd_clear,
    output logic       o_busy,
    output logic       o_err,
    output logic [7:0] o_drop_cnt
);
    localparam int IW = $clog2(MAX_LEN + 1);
`ifdef UART_ECHO_EN
    localparam int OFS = 1;
`else
    localparam int OFS = 0;
`endif
    localparam logic [ACK_TO_W-1:0] TO_LAST = {ACK_TO_W{1'b1}} - 1'b1;

    typedef enum logic [2:0] {IDLE, BUILD, SEND, WAIT_ACK, WAIT_DONE} state_t;

    state_t              state;
    logic [7:0]          cmd;
    logic [7:0]          rsp_buf [MAX_LEN];
    logic [IW-1:0]       len;
    logic [IW-1:0]       idx;
    logic [ACK_TO_W-1:0] to_cnt;
    logic [15:0]         hh, mm, ss;

    function automatic logic [3:0] tens(input logic [5:0] v);
        if (v >= 6'd60)      return 4'd6;
        else if (v >= 6'd50) return 4'd5;
        else if (v >= 6'd40) return 4'd4;
        else if (v >= 6'd30) return 4'd3;
        else if (v >= 6'd20) return 4'd2;
        else if (v >= 6'd10) return 4'd1;
        else                 return 4'd0;
    endfunction

    // Two ASCII digits; values above 59 still yield tens=6 and a single units digit.
    function automatic logic [15:0] two_dig(input logic [5:0] v);
        logic [3:0] t;
        logic [5:0] u;
        t = tens(v);
        u = v - 6'({2'b00, t} * 6'd10);
        return {8'h30 + {4'h0, t}, 8'h30 + {4'h0, u[3:0]}};
    endfunction

    assign hh = two_dig({1'b0, i_hour});
    assign mm = two_dig(i_min);
    assign ss = two_dig(i_sec);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cmd         <= 8'h00;
            len         <= '0;
            idx         <= '0;
            to_cnt      <= '0;
            o_tx_data   <= 8'h00;
            o_tx_start  <= 1'b0;
            o_cmd_clear <= 1'b0;
            o_busy      <= 1'b0;
            o_err       <= 1'b0;
            o_drop_cnt  <= 8'h00;
            for (int i = 0; i < MAX_LEN; i++) rsp_buf[i] <= 8'h00;
        end else begin
            o_tx_start  <= 1'b0;
            o_cmd_clear <= 1'b0;
            o_err       <= 1'b0;
            if (i_rx_done && state != IDLE && o_drop_cnt != 8'hFF)
                o_drop_cnt <= o_drop_cnt + 8'd1;
            unique case (state)
                IDLE: begin
                    if (i_rx_done && i_rx_data != 8'h0D && i_rx_data != 8'h0A) begin
                        cmd         <= i_rx_data;
                        state       <= BUILD;
                        o_busy      <= 1'b1;
                        o_cmd_clear <= (i_rx_data == 8'h43) || (i_rx_data == 8'h63);
                    end
                end
                BUILD: begin
                    idx   <= '0;
                    state <= SEND;
`ifdef UART_ECHO_EN
                    rsp_buf[0] <= cmd;
`endif
                    unique case (cmd)
                        8'h54, 8'h74: begin
                            rsp_buf[OFS+0] <= hh[15:8];
                            rsp_buf[OFS+1] <= hh[7:0];
                            rsp_buf[OFS+2] <= 8'h3A;
                            rsp_buf[OFS+3] <= mm[15:8];
                            rsp_buf[OFS+4] <= mm[7:0];
                            rsp_buf[OFS+5] <= 8'h3A;
                            rsp_buf[OFS+6] <= ss[15:8];
                            rsp_buf[OFS+7] <= ss[7:0];
                            rsp_buf[OFS+8] <= 8'h0D;
                            rsp_buf[OFS+9] <= 8'h0A;
                            len            <= IW'(OFS + 10);
                        end
                        8'h43, 8'h63: begin
                            rsp_buf[OFS+0] <= 8'h4F;
                            rsp_buf[OFS+1] <= 8'h4B;
                            rsp_buf[OFS+2] <= 8'h0D;
                            rsp_buf[OFS+3] <= 8'h0A;
                            len            <= IW'(OFS + 4);
                        end
                        default: begin
                            rsp_buf[OFS+0] <= 8'h3F;
                            rsp_buf[OFS+1] <= 8'h0D;
                            rsp_buf[OFS+2] <= 8'h0A;
                            len            <= IW'(OFS + 3);
                        end
                    endcase
                end
                SEND: begin
                    if (!i_tx_busy) begin
                        o_tx_data  <= rsp_buf[idx];
                        o_tx_start <= 1'b1;
                        to_cnt     <= '0;
                        state      <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (i_tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (to_cnt == TO_LAST) begin
                        o_err  <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        if ((idx + 1'b1) == len) begin
                            o_busy <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= SEND;
                        end
                    end
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_responder.sv
// tb_uart_cmd_responder: random commands against a string-level reply model,
// with a behavioural transmitter that acknowledges each start after a random lag.
module tb_uart_cmd_responder;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_rx_done = 1'b0;
    logic       i_tx_busy = 1'b0;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic [4:0] i_hour = 5'd0;
    logic [5:0] i_min = 6'd0;
    logic [5:0] i_sec = 6'd0;
    logic       o_cmd_clear;
    logic       o_busy;
    logic       o_err;
    logic [7:0] o_drop_cnt;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_start = 0;
    int n_clear = 0;
    int n_err = 0;
    int n_busy = 0;
    int start_cyc = 0;
    int err_cyc = 0;
    bit dead = 1'b0;
    int exp_drop = 0;
    byte got[$];

    uart_cmd_responder #(.ACK_TO_W(4), .MAX_LEN(11)) dut (
        .clk(clk), .reset(reset),
        .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
        .i_tx_busy(i_tx_busy), .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
        .i_hour(i_hour), .i_min(i_min), .i_sec(i_sec),
        .o_cmd_clear(o_cmd_clear), .o_busy(o_busy), .o_err(o_err),
        .o_drop_cnt(o_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transmitter model plus event monitor, all sampled on the falling edge.
    int  dly = 0;
    int  hold = 0;
    bit  pend = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (o_tx_start) begin
            n_start++;
            start_cyc = cyc;
            got.push_back(o_tx_data);
        end
        if (o_cmd_clear) n_clear++;
        if (o_busy) n_busy++;
        if (o_err) begin
            n_err++;
            err_cyc = cyc;
        end
        if (reset) begin
            i_tx_busy = 1'b0;
            pend = 1'b0;
            hold = 0;
        end else begin
            if (o_tx_start && !dead) begin
                pend = 1'b1;
                dly = $urandom_range(1, 4);
            end
            if (pend) begin
                dly--;
                if (dly == 0) begin
                    pend = 1'b0;
                    i_tx_busy = 1'b1;
                    hold = $urandom_range(2, 6);
                end
            end else if (i_tx_busy) begin
                hold--;
                if (hold == 0) i_tx_busy = 1'b0;
            end
        end
    end

    function automatic string exp_rsp(input byte c, input int h, input int m, input int s);
        string r;
        if (c == 8'h0D || c == 8'h0A) return "";
        if (c == "T" || c == "t") r = $sformatf("%02d:%02d:%02d\r\n", h, m, s);
        else if (c == "C" || c == "c") r = "OK\r\n";
        else r = "?\r\n";
`ifdef UART_ECHO_EN
        r = $sformatf("%c%s", c, r);
`endif
        return r;
    endfunction

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < 3000 && !ok; k++) begin
            @(negedge clk);
            if (!o_busy) ok = 1'b1;
        end
        check({tag, "_idle_timeout"}, ok, 1);
    endtask

    task automatic pulse_rx(input byte c);
        @(negedge clk);
        i_rx_data = c;
        i_rx_done = 1'b1;
        @(negedge clk);
        i_rx_done = 1'b0;
    endtask

    task automatic run_cmd(input string tag, input byte c, input int h, input int m, input int s);
        string e;
        int s0, c0, b0;
        got.delete();
        s0 = n_start;
        c0 = n_clear;
        b0 = n_busy;
        i_hour = 5'(h);
        i_min = 6'(m);
        i_sec = 6'(s);
        pulse_rx(c);
        wait_idle(tag);
        repeat (3) @(negedge clk);
        e = exp_rsp(c, h, m, s);
        check({tag, "_len"}, got.size(), e.len());
        check({tag, "_starts"}, n_start - s0, e.len());
        for (int i = 0; i < e.len() && i < got.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), got[i], e[i]);
        check({tag, "_clear"}, n_clear - c0, (c == "C" || c == "c") ? 1 : 0);
        if (e.len() == 0) check({tag, "_busy_cycles"}, n_busy - b0, 0);
    endtask

    initial begin
        byte c;
        int s0, e0;
        bit ok;
        repeat (3) @(negedge clk);
        check("rst_tx_start", o_tx_start, 0);
        check("rst_tx_data", o_tx_data, 0);
        check("rst_busy", o_busy, 0);
        check("rst_err", o_err, 0);
        check("rst_clear", o_cmd_clear, 0);
        check("rst_drop", o_drop_cnt, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_cmd("time", "T", 9, 5, 42);
        run_cmd("clear", "c", 0, 0, 0);
        run_cmd("unknown", "Z", 0, 0, 0);
        run_cmd("cr", 8'h0D, 0, 0, 0);
        run_cmd("lf", 8'h0A, 0, 0, 0);
        run_cmd("oor", "t", 23, 63, 60);

        // Command arriving mid-reply is dropped.
        got.delete();
        s0 = n_clear;
        i_hour = 5'd12; i_min = 6'd34; i_sec = 6'd56;
        pulse_rx("T");
        @(negedge clk);
        i_rx_data = "C";
        i_rx_done = 1'b1;
        @(negedge clk);
        i_rx_done = 1'b0;
        exp_drop++;
        wait_idle("drop");
        repeat (3) @(negedge clk);
        check("drop_cnt", o_drop_cnt, exp_drop);
        check("drop_clear", n_clear - s0, 0);
        check("drop_len", got.size(), exp_rsp("T", 12, 34, 56).len());

        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 4))
                0: c = "T";
                1: c = "t";
                2: c = "C";
                3: c = "c";
                default: c = byte'($urandom_range(0, 255));
            endcase
            run_cmd($sformatf("rnd%0d", n), c, $urandom_range(0, 23),
                    $urandom_range(0, 63), $urandom_range(0, 63));
        end
        check("rnd_drop", o_drop_cnt, exp_drop);

        // Ack timeout: transmitter never raises busy.
        dead = 1'b1;
        s0 = n_start;
        e0 = n_err;
        pulse_rx("T");
        wait_idle("to");
        repeat (30) @(negedge clk);
        check("to_starts", n_start - s0, 1);
        check("to_errs", n_err - e0, 1);
        check("to_delay", err_cyc - start_cyc, 15);
        check("to_busy", o_busy, 0);
        dead = 1'b0;

        // Continuous strobes while busy saturate the drop counter.
        @(negedge clk);
        i_rx_data = "T";
        i_rx_done = 1'b1;
        repeat (400) @(negedge clk);
        i_rx_done = 1'b0;
        wait_idle("sat");
        check("sat_drop", o_drop_cnt, 255);

        // Asynchronous reset in the middle of a reply.
        s0 = n_start;
        i_hour = 5'd1; i_min = 6'd2; i_sec = 6'd3;
        pulse_rx("T");
        ok = 1'b0;
        for (int k = 0; k < 500 && !ok; k++) begin
            @(negedge clk);
            if (n_start - s0 >= 3) ok = 1'b1;
        end
        check("mid_reach3", ok, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_busy", o_busy, 0);
        check("mid_tx_data", o_tx_data, 0);
        check("mid_drop", o_drop_cnt, 0);
        check("mid_tx_start", o_tx_start, 0);
        s0 = n_start;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("mid_no_start", n_start - s0, 0);
        run_cmd("post_rst", "T", 20, 59, 7);
        check("post_rst_drop", o_drop_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
